frontend_trigger_csr: RTL
=========================

FRONTEND_TRIGGER_CSR -- requirements
Module: frontend_trigger_csr

Interface
REQ-001 SHALL provide ports: clock  in  1  sole clock; all state on rising edge.
REQ-002 SHALL provide ports: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL provide ports: csr_wen in 1 CSR write strobe; csr_waddr in 12 write address; csr_wdata in 64 write data.
REQ-004 SHALL provide ports: csr_ren in 1 read strobe; csr_raddr in 12 read address; csr_rdata out 64 read data.
REQ-005 SHALL provide ports: priv in 2 current privilege (0 U, 1 S, 3 M); debug_mode_in in 1 hart in debug mode; tcontrol_mte in 1 M-mode trigger enable.
REQ-006 SHALL provide ports: io_frontendTrigger_tUpdate_valid out 1; io_frontendTrigger_tUpdate_bits_addr out 2; io_frontendTrigger_tUpdate_bits_tdata_matchType out 2; _select out 1; _action out 4; _chain out 1; _tdata2 out 64.
REQ-007 SHALL provide ports: io_frontendTrigger_tEnableVec_0..3 out 1 each; io_frontendTrigger_debugMode out 1; io_frontendTrigger_triggerCanRaiseBpExp out 1.

Function
REQ-008 SHALL hold 4 trigger entries (tdata1 fields: dmode, select, action, chain, match, m, s, u, execute; tdata2 64 bits) and a 2-bit tselect.
REQ-009 SHALL decode CSR addresses 0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2; other addresses ignored on write, read 0.
REQ-010 SHALL treat tselect as WARL: write value >3 leaves tselect unchanged.
REQ-011 SHALL extract mcontrol fields: type[63:60], dmode[59], select[19], action[15:12], chain[11], match[10:7], m[6], s[4], u[3], execute[2].
REQ-012 SHALL ignore a tdata1 write whose type != 2, and ignore any tdata1/tdata2 write to an entry with dmode=1 while debug_mode_in=0.
REQ-013 SHALL legalize: match 0/2/3 map to matchType 0/2/3, any other match stores 0; action >1 stores 0; chain of entry 3 forced 0; dmode writable only when debug_mode_in=1.
REQ-014 SHALL, on each accepted tdata1 or tdata2 write, assert tUpdate_valid exactly one cycle later for one cycle, with addr = tselect at write time and tdata fields = that entry's post-write contents.
REQ-015 SHALL handle back-to-back accepted writes with one tUpdate pulse per write, no merging or loss.
REQ-016 SHALL keep tUpdate_valid low for ignored writes, tselect writes, and reads.
REQ-017 SHALL register tEnableVec_i = execute_i AND ((priv=3 AND m_i) OR (priv=1 AND s_i) OR (priv=0 AND u_i)), one-cycle latency from any input/state change.
REQ-018 SHALL register io_frontendTrigger_debugMode = debug_mode_in, one-cycle latency.
REQ-019 SHALL register triggerCanRaiseBpExp = (priv != 3) OR tcontrol_mte, one-cycle latency.
REQ-020 SHALL return csr_rdata one cycle after csr_ren, reflecting state including a same-cycle write (write-first); csr_rdata holds its value when csr_ren=0.
REQ-021 SHALL read tdata1 as type=2 in [63:60] plus stored fields, all other bits 0.

Reset
REQ-022 SHALL, while reset=0, clear immediately: tselect=0, all entry fields and tdata2=0, tUpdate_valid=0, tUpdate bits=0, tEnableVec=0, debugMode=0, triggerCanRaiseBpExp=0, csr_rdata=0.
REQ-023 SHALL drop a pending tUpdate pulse if reset asserts between write and pulse cycle.
REQ-024 SHALL produce first registered output updates on the first rising edge after reset deasserts.

Structure
REQ-025 SHALL place CSR addresses, mcontrol bit offsets, match-type encodings and trigger count (4) in shared package trigger_pkg.
REQ-026 SHALL implement per-entry storage and legalization in one sub-module, trigger_entry_reg, instantiated 4 times.

Verification
REQ-027 SHALL cover: tselect=1, write tdata2=0x8000_1000 -> next cycle tUpdate_valid=1, addr=1, tdata2=0x8000_1000, single cycle.
REQ-028 SHALL cover: write tdata1 type=2, match=5, action=3 -> stored matchType=0, action=0; readback tdata1 shows match=0, type=2.
REQ-029 SHALL cover: entry 0 execute=1, m=1, priv=3 -> tEnableVec_0=1 one cycle later; priv changes to 0 -> tEnableVec_0=0 one cycle later.
REQ-030 SHALL cover: tselect write 5 -> tselect stays prior value; tdata1 write type=0 -> no tUpdate pulse, entry unchanged.
REQ-031 SHALL cover: three consecutive accepted writes -> three consecutive tUpdate pulses; reset=0 on cycle after last write -> no pulse, all outputs 0.
REQ-032 SHALL cover: priv=3, tcontrol_mte=0 -> triggerCanRaiseBpExp=0; tcontrol_mte=1 -> 1 one cycle later.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared definitions for the frontend trigger CSR block: CSR addresses,
// mcontrol bit positions, match-type encodings, the trigger count, the
// per-entry stored-field struct and the legalize/readback helpers.
package trigger_pkg;

  localparam int NUM_TRIGGERS = 4;

  localparam logic [11:0] CSR_TSELECT = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

  // mcontrol bit offsets
  localparam int MC_TYPE_HI   = 63;
  localparam int MC_TYPE_LO   = 60;
  localparam int MC_DMODE     = 59;
  localparam int MC_SELECT    = 19;
  localparam int MC_ACTION_HI = 15;
  localparam int MC_ACTION_LO = 12;
  localparam int MC_CHAIN     = 11;
  localparam int MC_MATCH_HI  = 10;
  localparam int MC_MATCH_LO  = 7;
  localparam int MC_M         = 6;
  localparam int MC_S         = 4;
  localparam int MC_U         = 3;
  localparam int MC_EXECUTE   = 2;

  localparam logic [3:0] MCONTROL_TYPE = 4'd2;

  // Match-type encodings kept by the hardware
  localparam logic [1:0] MT_EQUAL = 2'd0;
  localparam logic [1:0] MT_GE    = 2'd2;
  localparam logic [1:0] MT_LT    = 2'd3;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef struct packed {
    logic       dmode;
    logic       select;
    logic [3:0] action;
    logic       chain;
    logic [1:0] match_type;
    logic       m;
    logic       s;
    logic       u;
    logic       execute;
  } tdata1_t;

  // Turn a raw mcontrol write into the fields this hardware can hold.
  function automatic tdata1_t legalize_mcontrol(input logic [63:0] wdata,
                                                input logic        old_dmode,
                                                input logic        debug_mode,
                                                input logic        is_last);
    tdata1_t    t;
    logic [3:0] w_match;
    logic [3:0] w_action;
    w_match  = wdata[MC_MATCH_HI:MC_MATCH_LO];
    w_action = wdata[MC_ACTION_HI:MC_ACTION_LO];
    t.dmode  = debug_mode ? wdata[MC_DMODE] : old_dmode;
    t.select = wdata[MC_SELECT];
    t.action = (w_action > 4'd1) ? 4'd0 : w_action;
    // The last trigger has nothing to chain into.
    t.chain  = is_last ? 1'b0 : wdata[MC_CHAIN];
    case (w_match)
      4'd0:    t.match_type = MT_EQUAL;
      4'd2:    t.match_type = MT_GE;
      4'd3:    t.match_type = MT_LT;
      default: t.match_type = MT_EQUAL;
    endcase
    t.m       = wdata[MC_M];
    t.s       = wdata[MC_S];
    t.u       = wdata[MC_U];
    t.execute = wdata[MC_EXECUTE];
    return t;
  endfunction

  // Software view of tdata1: type is always mcontrol, unheld bits read 0.
  function automatic logic [63:0] tdata1_read(input tdata1_t t);
    logic [63:0] r;
    r = 64'd0;
    r[MC_TYPE_HI:MC_TYPE_LO]     = MCONTROL_TYPE;
    r[MC_DMODE]                  = t.dmode;
    r[MC_SELECT]                 = t.select;
    r[MC_ACTION_HI:MC_ACTION_LO] = t.action;
    r[MC_CHAIN]                  = t.chain;
    r[MC_MATCH_HI:MC_MATCH_LO]   = {2'b00, t.match_type};
    r[MC_M]                      = t.m;
    r[MC_S]                      = t.s;
    r[MC_U]                      = t.u;
    r[MC_EXECUTE]                = t.execute;
    return r;
  endfunction

endpackage

// File: rtl/trigger_entry_reg.sv
// One trigger entry: tdata1 fields and tdata2, with write acceptance and
// legalization.
// Ports: clock/reset; i_wen_tdata1/i_wen_tdata2 write strobes already
// qualified by tselect; i_wdata write data; i_debug_mode hart debug state;
// o_accept write accepted this cycle; o_tdata1/o_tdata2 stored state;
// o_tdata1_nxt/o_tdata2_nxt the state after this cycle's write.
module trigger_entry_reg
  import trigger_pkg::*;
#(
  parameter bit IS_LAST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_wen_tdata1,
  input  logic        i_wen_tdata2,
  input  logic [63:0] i_wdata,
  input  logic        i_debug_mode,
  output logic        o_accept,
  output tdata1_t     o_tdata1,
  output tdata1_t     o_tdata1_nxt,
  output logic [63:0] o_tdata2,
  output logic [63:0] o_tdata2_nxt
);

  tdata1_t     r_tdata1;
  logic [63:0] r_tdata2;
  tdata1_t     w_tdata1_nxt;
  logic [63:0] w_tdata2_nxt;
  logic        w_locked;
  logic        w_acc_t1;
  logic        w_acc_t2;

  // Acceptance and next-state: debug-owned entries are locked outside debug mode.
  always_comb begin
    w_locked     = r_tdata1.dmode & ~i_debug_mode;
    w_acc_t1     = i_wen_tdata1 & ~w_locked &
                   (i_wdata[MC_TYPE_HI:MC_TYPE_LO] == MCONTROL_TYPE);
    w_acc_t2     = i_wen_tdata2 & ~w_locked;
    w_tdata1_nxt = r_tdata1;
    w_tdata2_nxt = r_tdata2;
    if (w_acc_t1) begin
      w_tdata1_nxt = legalize_mcontrol(i_wdata, r_tdata1.dmode, i_debug_mode, IS_LAST);
    end else begin
      w_tdata1_nxt = r_tdata1;
    end
    if (w_acc_t2) begin
      w_tdata2_nxt = i_wdata;
    end else begin
      w_tdata2_nxt = r_tdata2;
    end
  end

  // Entry state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tdata1 <= '0;
      r_tdata2 <= 64'd0;
    end else begin
      r_tdata1 <= w_tdata1_nxt;
      r_tdata2 <= w_tdata2_nxt;
    end
  end

  assign o_accept     = w_acc_t1 | w_acc_t2;
  assign o_tdata1     = r_tdata1;
  assign o_tdata1_nxt = w_tdata1_nxt;
  assign o_tdata2     = r_tdata2;
  assign o_tdata2_nxt = w_tdata2_nxt;

endmodule

// File: rtl/frontend_trigger_csr.sv
// Frontend trigger CSR block: tselect/tdata1/tdata2 access to four mcontrol
// triggers, update notification towards the frontend, and registered
// per-trigger enables for the current privilege level.
// Ports: clock, reset (async active-low); csr_wen/csr_waddr/csr_wdata write;
// csr_ren/csr_raddr/csr_rdata read (one-cycle, write-first); priv,
// debug_mode_in, tcontrol_mte status; io_frontendTrigger_* outputs
// (tUpdate pulse + bits, tEnableVec_0..3, debugMode, triggerCanRaiseBpExp).
module frontend_trigger_csr
  import trigger_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_wen,
  input  logic [11:0] csr_waddr,
  input  logic [63:0] csr_wdata,
  input  logic        csr_ren,
  input  logic [11:0] csr_raddr,
  output logic [63:0] csr_rdata,
  input  logic [1:0]  priv,
  input  logic        debug_mode_in,
  input  logic        tcontrol_mte,
  output logic        io_frontendTrigger_tUpdate_valid,
  output logic [1:0]  io_frontendTrigger_tUpdate_bits_addr,
  output logic [1:0]  io_frontendTrigger_tUpdate_bits_tdata_matchType,
  output logic        io_frontendTrigger_tUpdate_bits_tdata_select,
  output logic [3:0]  io_frontendTrigger_tUpdate_bits_tdata_action,
  output logic        io_frontendTrigger_tUpdate_bits_tdata_chain,
  output logic [63:0] io_frontendTrigger_tUpdate_bits_tdata_tdata2,
  output logic        io_frontendTrigger_tEnableVec_0,
  output logic        io_frontendTrigger_tEnableVec_1,
  output logic        io_frontendTrigger_tEnableVec_2,
  output logic        io_frontendTrigger_tEnableVec_3,
  output logic        io_frontendTrigger_debugMode,
  output logic        io_frontendTrigger_triggerCanRaiseBpExp
);

  logic [1:0]               r_tselect;
  logic [1:0]               w_tselect_nxt;
  logic                     w_wr_tselect;
  logic                     w_wr_tdata1;
  logic                     w_wr_tdata2;
  logic [NUM_TRIGGERS-1:0]  w_accept;
  logic                     w_upd;
  tdata1_t                  w_t1     [NUM_TRIGGERS];
  tdata1_t                  w_t1_nxt [NUM_TRIGGERS];
  logic [63:0]              w_t2     [NUM_TRIGGERS];
  logic [63:0]              w_t2_nxt [NUM_TRIGGERS];
  tdata1_t                  w_sel_t1_nxt;
  logic [63:0]              w_sel_t2_nxt;
  logic [63:0]              w_rdata;
  logic [NUM_TRIGGERS-1:0]  w_en;

  logic                     r_upd_valid;
  logic [1:0]               r_upd_addr;
  tdata1_t                  r_upd_t1;
  logic [63:0]              r_upd_t2;
  logic [NUM_TRIGGERS-1:0]  r_en;
  logic                     r_debug_mode;
  logic                     r_bp_exp;
  logic [63:0]              r_rdata;

  // Write decode and WARL tselect next value.
  always_comb begin
    w_wr_tselect  = csr_wen & (csr_waddr == CSR_TSELECT);
    w_wr_tdata1   = csr_wen & (csr_waddr == CSR_TDATA1);
    w_wr_tdata2   = csr_wen & (csr_waddr == CSR_TDATA2);
    w_tselect_nxt = r_tselect;
    if (w_wr_tselect && (csr_wdata[63:2] == 62'd0)) begin
      w_tselect_nxt = csr_wdata[1:0];
    end else begin
      w_tselect_nxt = r_tselect;
    end
  end

  for (genvar i = 0; i < NUM_TRIGGERS; i++) begin : g_entry
    trigger_entry_reg #(
      .IS_LAST(i == NUM_TRIGGERS - 1)
    ) u_entry (
      .clock        (clock),
      .reset        (reset),
      .i_wen_tdata1 (w_wr_tdata1 & (r_tselect == 2'(i))),
      .i_wen_tdata2 (w_wr_tdata2 & (r_tselect == 2'(i))),
      .i_wdata      (csr_wdata),
      .i_debug_mode (debug_mode_in),
      .o_accept     (w_accept[i]),
      .o_tdata1     (w_t1[i]),
      .o_tdata1_nxt (w_t1_nxt[i]),
      .o_tdata2     (w_t2[i]),
      .o_tdata2_nxt (w_t2_nxt[i])
    );
  end

  // Update payload is the written entry's post-write contents, captured now so
  // a following write cannot alter a pulse already in flight.
  always_comb begin
    w_upd        = |w_accept;
    w_sel_t1_nxt = w_t1_nxt[r_tselect];
    w_sel_t2_nxt = w_t2_nxt[r_tselect];
  end

  // Write-first read mux: sees tselect and entry state after this cycle's write.
  always_comb begin
    w_rdata = 64'd0;
    case (csr_raddr)
      CSR_TSELECT: w_rdata = {62'd0, w_tselect_nxt};
      CSR_TDATA1:  w_rdata = tdata1_read(w_t1_nxt[w_tselect_nxt]);
      CSR_TDATA2:  w_rdata = w_t2_nxt[w_tselect_nxt];
      default:     w_rdata = 64'd0;
    endcase
  end

  // Per-trigger execute enable for the current privilege (priv 2 is reserved).
  always_comb begin
    w_en = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      w_en[i] = w_t1[i].execute & (((priv == PRIV_M) & w_t1[i].m) |
                                   ((priv == PRIV_S) & w_t1[i].s) |
                                   ((priv == PRIV_U) & w_t1[i].u));
    end
  end

  // tselect, update pulse and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tselect    <= 2'd0;
      r_upd_valid  <= 1'b0;
      r_upd_addr   <= 2'd0;
      r_upd_t1     <= '0;
      r_upd_t2     <= 64'd0;
      r_en         <= '0;
      r_debug_mode <= 1'b0;
      r_bp_exp     <= 1'b0;
      r_rdata      <= 64'd0;
    end else begin
      r_tselect    <= w_tselect_nxt;
      r_upd_valid  <= w_upd;
      if (w_upd) begin
        r_upd_addr <= r_tselect;
        r_upd_t1   <= w_sel_t1_nxt;
        r_upd_t2   <= w_sel_t2_nxt;
      end else begin
        r_upd_addr <= r_upd_addr;
        r_upd_t1   <= r_upd_t1;
        r_upd_t2   <= r_upd_t2;
      end
      r_en         <= w_en;
      r_debug_mode <= debug_mode_in;
      r_bp_exp     <= (priv != PRIV_M) | tcontrol_mte;
      if (csr_ren) begin
        r_rdata <= w_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign csr_rdata                                       = r_rdata;
  assign io_frontendTrigger_tUpdate_valid                = r_upd_valid;
  assign io_frontendTrigger_tUpdate_bits_addr            = r_upd_addr;
  assign io_frontendTrigger_tUpdate_bits_tdata_matchType = r_upd_t1.match_type;
  assign io_frontendTrigger_tUpdate_bits_tdata_select    = r_upd_t1.select;
  assign io_frontendTrigger_tUpdate_bits_tdata_action    = r_upd_t1.action;
  assign io_frontendTrigger_tUpdate_bits_tdata_chain     = r_upd_t1.chain;
  assign io_frontendTrigger_tUpdate_bits_tdata_tdata2    = r_upd_t2;
  assign io_frontendTrigger_tEnableVec_0                 = r_en[0];
  assign io_frontendTrigger_tEnableVec_1                 = r_en[1];
  assign io_frontendTrigger_tEnableVec_2                 = r_en[2];
  assign io_frontendTrigger_tEnableVec_3                 = r_en[3];
  assign io_frontendTrigger_debugMode                    = r_debug_mode;
  assign io_frontendTrigger_triggerCanRaiseBpExp         = r_bp_exp;

endmodule
